// File: rtl/io_expander_pkg.sv
// rtl/io_expander_pkg.sv - register map, FSM encoding and defaults shared by the GPIO expander
package io_expander_pkg;

  localparam int unsigned GPIO_WIDTH        = 8;
  localparam logic [7:0]  DEVICE_ID_DEFAULT = 8'hA5;
  localparam logic [7:0]  RESET_DIR_DEFAULT = 8'h00;

  localparam logic [3:0] ADDR_DIR      = 4'h0;
  localparam logic [3:0] ADDR_OUT      = 4'h1;
  localparam logic [3:0] ADDR_IN       = 4'h2;
  localparam logic [3:0] ADDR_IRQ_EN   = 4'h3;
  localparam logic [3:0] ADDR_IRQ_STAT = 4'h4;
  localparam logic [3:0] ADDR_ID       = 4'h5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } bank_state_t;

  // True for addresses backed by a register that a write can change
  function automatic logic addr_is_writable(input logic [3:0] addr);
    return (addr == ADDR_DIR) || (addr == ADDR_OUT) ||
           (addr == ADDR_IRQ_EN) || (addr == ADDR_IRQ_STAT);
  endfunction

endpackage

// File: rtl/io_register_bank_if.sv
// rtl/io_register_bank_if.sv - address/strobe/handshake bundle between address generator and register bank
interface io_register_bank_if;
  logic [3:0] addressBus;
  logic       rw;
  logic       en;
  logic       ack;

  modport master (output addressBus, output rw, output en, input ack);
  modport slave  (input addressBus, input rw, input en, output ack);
endinterface

// File: rtl/gpio_input_sync.sv
// rtl/gpio_input_sync.sv - two-flop pin synchroniser with both-edge change detect, muted while it fills after reset
module gpio_input_sync
  import io_expander_pkg::*;
#(
  parameter int unsigned WIDTH = GPIO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] levels,
  output logic [WIDTH-1:0] change
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [1:0]       fill_cnt;
  logic             armed;

  // Synchroniser chain plus one-cycle history of the synchronised level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= '0;
      stable <= '0;
      prev   <= '0;
    end else begin
      meta   <= pins;
      stable <= meta;
      prev   <= stable;
    end
  end

  // Arm change detect only once the chain and its history hold real pin levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt <= 2'd0;
      armed    <= 1'b0;
    end else begin
      if (fill_cnt != 2'd2) begin
        fill_cnt <= fill_cnt + 2'd1;
      end
      armed <= (fill_cnt == 2'd2);
    end
  end

  assign levels = stable;
  assign change = armed ? (stable ^ prev) : '0;

endmodule

// File: rtl/io_register_bank.sv
// rtl/io_register_bank.sv - GPIO expander register bank with en/ack handshake and pin-change interrupt
module io_register_bank
  import io_expander_pkg::*;
#(
  parameter logic [7:0] RESET_DIR = RESET_DIR_DEFAULT,
  parameter logic [7:0] DEVICE_ID = DEVICE_ID_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  io_register_bank_if.slave bus,
  inout  wire  [7:0]        dataBus,
  input  logic [7:0]        gpioIn,
  output logic [7:0]        gpioOut,
  output logic [7:0]        gpioOe,
  output logic              irq
);

  bank_state_t state;
  bank_state_t state_next;

  logic       en_q;
  logic       en_rise;
  logic       start;
  logic       do_access;
  logic       wr_strobe;
  logic [3:0] lat_addr;
  logic       lat_rw;
  logic [7:0] lat_data;

  logic [7:0] dir_q;
  logic [7:0] out_q;
  logic [7:0] irq_en_q;
  logic [7:0] irq_stat_q;
  logic [7:0] rdata_q;
  logic [7:0] read_value;
  logic [7:0] w1c_mask;
  logic       irq_q;

  logic [7:0] pin_level;
  logic [7:0] pin_change;

  gpio_input_sync #(.WIDTH(GPIO_WIDTH)) u_input_sync (
    .clk    (clk),
    .rst    (rst),
    .pins   (gpioIn),
    .levels (pin_level),
    .change (pin_change)
  );

  assign en_rise = bus.en && !en_q;

  // Previous-cycle strobe level for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) en_q <= 1'b0;
    else     en_q <= bus.en;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state; edges seen outside IDLE are dropped, ACK waits for the strobe to fall
  always_comb begin
    state_next = state;
    start      = 1'b0;
    do_access  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (en_rise) begin
          state_next = ST_ACCESS;
          start      = 1'b1;
        end
      end
      ST_ACCESS: begin
        do_access  = 1'b1;
        state_next = ST_ACK;
      end
      ST_ACK: begin
        if (!bus.en) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture address, direction and write data on the accepted edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr <= '0;
      lat_rw   <= 1'b0;
      lat_data <= '0;
    end else if (start) begin
      lat_addr <= bus.addressBus;
      lat_rw   <= bus.rw;
      lat_data <= dataBus;
    end
  end

  assign wr_strobe = do_access && !lat_rw && addr_is_writable(lat_addr);
  assign w1c_mask  = (wr_strobe && (lat_addr == ADDR_IRQ_STAT)) ? lat_data : 8'h00;

  // Plain read/write control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q    <= RESET_DIR;
      out_q    <= 8'h00;
      irq_en_q <= 8'h00;
    end else if (wr_strobe) begin
      case (lat_addr)
        ADDR_DIR:    dir_q    <= lat_data;
        ADDR_OUT:    out_q    <= lat_data;
        ADDR_IRQ_EN: irq_en_q <= lat_data;
        default:     ;
      endcase
    end
  end

  // Sticky pin-change flags; a fresh change beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_stat_q <= 8'h00;
    else     irq_stat_q <= (irq_stat_q & ~w1c_mask) | pin_change;
  end

  // Register-map read decode
  always_comb begin
    read_value = 8'h00;
    case (lat_addr)
      ADDR_DIR:      read_value = dir_q;
      ADDR_OUT:      read_value = out_q;
      ADDR_IN:       read_value = pin_level;
      ADDR_IRQ_EN:   read_value = irq_en_q;
      ADDR_IRQ_STAT: read_value = irq_stat_q;
      ADDR_ID:       read_value = DEVICE_ID;
      default:       read_value = 8'h00;
    endcase
  end

  // Read snapshot taken in ACCESS so later changes do not leak into ACK
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       rdata_q <= 8'h00;
    else if (do_access && lat_rw)  rdata_q <= read_value;
  end

  // Registered interrupt level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= |(irq_stat_q & irq_en_q);
  end

  assign bus.ack = (state == ST_ACK);
  assign dataBus = ((state == ST_ACK) && lat_rw) ? rdata_q : 8'hzz;
  assign gpioOut = out_q;
  assign gpioOe  = dir_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_io_register_bank.sv
// tb/tb_io_register_bank.sv - self-checking bench for io_register_bank
module tb_io_register_bank;
  import io_expander_pkg::*;

  localparam logic [7:0] TB_RESET_DIR = 8'h5C;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic [7:0] gpio_oe;
  logic       irq;
  logic [7:0] tb_data;
  logic       tb_drive;
  wire  [7:0] data_bus;

  io_register_bank_if bus ();

  assign data_bus = tb_drive ? tb_data : 8'hzz;

  io_register_bank #(.RESET_DIR(TB_RESET_DIR)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .dataBus (data_bus),
    .gpioIn  (gpio_in),
    .gpioOut (gpio_out),
    .gpioOe  (gpio_oe),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [7:0] m_dir, m_out, m_en, m_stat, m_pins;

  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [7:0] out;
    logic [7:0] oe;
  } vec_t;

  vec_t vt [14];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic rd, input logic [3:0] addr, input logic [7:0] wd,
                        output logic [7:0] rv, output logic [7:0] out_ack, output logic [7:0] oe_ack);
    int lat;
    bus.addressBus = addr;
    bus.rw         = rd;
    bus.en         = 1'b1;
    tb_data        = wd;
    tb_drive       = !rd;
    lat            = 0;
    do begin
      tick();
      lat++;
    end while (bus.ack !== 1'b1 && lat < 12);
    check("ack_latency", 16'(lat), 16'd2);
    rv      = data_bus;
    out_ack = gpio_out;
    oe_ack  = gpio_oe;
    bus.en   = 1'b0;
    tb_drive = 1'b0;
    tick();
    check("ack_release", 16'(bus.ack), 16'd0);
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    logic [7:0] o, e;
    access(1'b1, a, 8'h00, v, o, e);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] v, o, e;
    access(1'b0, a, d, v, o, e);
  endtask

  task automatic run_pattern(input string name, input logic [15:0] en_pat, input logic [15:0] ack_exp,
                             input logic rdq, input logic [3:0] addr, input logic [7:0] wbase);
    logic [15:0] seen;
    seen = '0;
    bus.addressBus = addr;
    bus.rw         = rdq;
    tb_drive       = !rdq;
    for (int c = 0; c < 16; c++) begin
      bus.en  = en_pat[c];
      tb_data = wbase + 8'(c);
      seen[c] = bus.ack;
      tick();
    end
    bus.en   = 1'b0;
    tb_drive = 1'b0;
    check(name, seen, ack_exp);
  endtask

  function automatic logic [7:0] model_read(input logic [3:0] a);
    case (a)
      4'h0:    return m_dir;
      4'h1:    return m_out;
      4'h2:    return m_pins;
      4'h3:    return m_en;
      4'h4:    return m_stat;
      4'h5:    return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_write(input logic [3:0] a, input logic [7:0] d);
    case (a)
      4'h0:    m_dir  = d;
      4'h1:    m_out  = d;
      4'h3:    m_en   = d;
      4'h4:    m_stat = m_stat & ~d;
      default: ;
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rv, o_ack, e_ack, d, np;
    logic [3:0] a;
    logic       rq;

    vt[0]  = '{1'b0, 4'h1, 8'h3C, 8'h00, 8'h3C, TB_RESET_DIR};
    vt[1]  = '{1'b1, 4'h1, 8'h00, 8'h3C, 8'h3C, TB_RESET_DIR};
    vt[2]  = '{1'b0, 4'h0, 8'hF0, 8'h00, 8'h3C, 8'hF0};
    vt[3]  = '{1'b1, 4'h0, 8'h00, 8'hF0, 8'h3C, 8'hF0};
    vt[4]  = '{1'b0, 4'h2, 8'hFF, 8'h00, 8'h3C, 8'hF0};
    vt[5]  = '{1'b1, 4'h2, 8'h00, 8'h00, 8'h3C, 8'hF0};
    vt[6]  = '{1'b0, 4'h5, 8'h00, 8'h00, 8'h3C, 8'hF0};
    vt[7]  = '{1'b1, 4'h5, 8'h00, 8'hA5, 8'h3C, 8'hF0};
    vt[8]  = '{1'b0, 4'hF, 8'h77, 8'h00, 8'h3C, 8'hF0};
    vt[9]  = '{1'b1, 4'hF, 8'h00, 8'h00, 8'h3C, 8'hF0};
    vt[10] = '{1'b0, 4'h3, 8'h81, 8'h00, 8'h3C, 8'hF0};
    vt[11] = '{1'b1, 4'h3, 8'h00, 8'h81, 8'h3C, 8'hF0};
    vt[12] = '{1'b1, 4'h7, 8'h00, 8'h00, 8'h3C, 8'hF0};
    vt[13] = '{1'b0, 4'h1, 8'hA6, 8'h00, 8'hA6, 8'hF0};

    rst = 1'b1;
    bus.en = 1'b0;
    bus.rw = 1'b0;
    bus.addressBus = 4'h0;
    tb_drive = 1'b0;
    tb_data = 8'h00;
    gpio_in = 8'h00;
    tick();
    tick();

    check("reset_ack", 16'(bus.ack), 16'd0);
    check("reset_out", 16'(gpio_out), 16'h0000);
    check("reset_oe", 16'(gpio_oe), 16'(TB_RESET_DIR));
    check("reset_irq", 16'(irq), 16'd0);
    tb_drive = 1'b1;
    tb_data  = 8'h5A;
    #1;
    check("reset_bus_released", 16'(data_bus), 16'h005A);
    tb_drive = 1'b0;
    rst = 1'b0;
    tick();
    rd(ADDR_IRQ_STAT, rv);
    check("reset_irq_stat", 16'(rv), 16'h0000);

    for (int i = 0; i < 14; i++) begin
      access(vt[i].rd, vt[i].addr, vt[i].wdata, rv, o_ack, e_ack);
      if (vt[i].rd) check($sformatf("vec%0d_rdata", i), 16'(rv), 16'(vt[i].rdata));
      else          check($sformatf("vec%0d_not_driven", i), 16'(rv), 16'(vt[i].wdata));
      check($sformatf("vec%0d_out_at_ack", i), 16'(o_ack), 16'(vt[i].out));
      check($sformatf("vec%0d_oe_at_ack", i), 16'(e_ack), 16'(vt[i].oe));
    end

    wr(ADDR_IRQ_EN, 8'h01);
    gpio_in = 8'h01;
    tick();
    tick();
    tick();
    check("irq_not_yet", 16'(irq), 16'd0);
    tick();
    check("irq_raised", 16'(irq), 16'd1);
    rd(ADDR_IRQ_STAT, rv);
    check("irq_stat_set", 16'(rv), 16'h0001);
    wr(ADDR_IRQ_STAT, 8'h01);
    check("irq_after_w1c", 16'(irq), 16'd0);
    rd(ADDR_IRQ_STAT, rv);
    check("irq_stat_cleared", 16'(rv), 16'h0000);

    gpio_in = 8'h00;
    repeat (5) tick();
    gpio_in = 8'h01;
    tick();
    wr(ADDR_IRQ_STAT, 8'h01);
    rd(ADDR_IRQ_STAT, rv);
    check("collision_set_wins", 16'(rv), 16'h0001);
    wr(ADDR_IRQ_STAT, 8'hFF);

    run_pattern("hold_en_10", 16'h03FF, 16'h07FC, 1'b1, ADDR_ID, 8'h00);
    run_pattern("edge_in_busy", 16'h001D, 16'h003C, 1'b0, ADDR_OUT, 8'h40);
    check("edge_in_busy_out", 16'(gpio_out), 16'h0040);

    wr(ADDR_DIR, 8'hAA);
    bus.addressBus = ADDR_DIR;
    bus.rw = 1'b1;
    bus.en = 1'b1;
    tick();
    tick();
    check("mid_ack_ack", 16'(bus.ack), 16'd1);
    check("mid_ack_data", 16'(data_bus), 16'h00AA);
    #2 rst = 1'b1;
    #1;
    check("async_reset_ack", 16'(bus.ack), 16'd0);
    tb_drive = 1'b1;
    tb_data  = 8'h5A;
    #1;
    check("async_reset_bus", 16'(data_bus), 16'h005A);
    tb_drive = 1'b0;
    bus.en   = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rd(ADDR_DIR, rv);
    check("dir_after_reset", 16'(rv), 16'(TB_RESET_DIR));

    bus.addressBus = ADDR_OUT;
    bus.rw = 1'b0;
    bus.en = 1'b1;
    tb_data = 8'h99;
    tb_drive = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    bus.en = 1'b0;
    tb_drive = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("aborted_write", 16'(gpio_out), 16'h0000);

    gpio_in = 8'hFF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    rd(ADDR_IRQ_STAT, rv);
    check("no_irq_from_sync_fill", 16'(rv), 16'h0000);
    rd(ADDR_IN, rv);
    check("in_after_fill", 16'(rv), 16'h00FF);

    m_dir  = TB_RESET_DIR;
    m_out  = 8'h00;
    m_en   = 8'h00;
    m_stat = 8'h00;
    m_pins = 8'hFF;
    for (int i = 0; i < 48; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        np = 8'($urandom);
        m_stat  = m_stat | (np ^ m_pins);
        m_pins  = np;
        gpio_in = np;
        repeat (5) tick();
      end
      if ($urandom_range(0, 3) == 0) a = 4'($urandom_range(0, 15));
      else                           a = 4'($urandom_range(0, 5));
      rq = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      if (rq) begin
        rd(a, rv);
        check($sformatf("rand%0d_read_a%0h", i, a), 16'(rv), 16'(model_read(a)));
      end else begin
        wr(a, d);
        model_write(a, d);
      end
      check($sformatf("rand%0d_pins_out", i), {gpio_oe, gpio_out}, {m_dir, m_out});
      check($sformatf("rand%0d_irq", i), 16'(irq), 16'(|(m_stat & m_en)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
